// File: rtl/battleship_board_engine.sv
// Two-board battleship engine: ship placement with bounds/overlap/fleet checks,
// attack resolution and board clearing behind one command/response handshake.
module battleship_board_engine #(
  parameter int ROWS      = 5,
  parameter int COLS      = 5,
  parameter int COORD_W   = 3,
  parameter int MAX_SHIPS = 5,
  parameter int MAX_LEN   = 3,
  parameter int LEN_W     = 2,
  parameter int CNT_W     = 5
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       cmd_valid_i,
  output logic                       cmd_ready_o,
  input  logic [1:0]                 cmd_op_i,
  input  logic                       cmd_board_i,
  input  logic [COORD_W-1:0]         cmd_row_i,
  input  logic [COORD_W-1:0]         cmd_col_i,
  input  logic [LEN_W-1:0]           cmd_len_i,
  input  logic                       cmd_vert_i,
  output logic                       rsp_valid_o,
  output logic [2:0]                 rsp_code_o,
  output logic [2*ROWS*COLS-1:0]     board_player_o,
  output logic [2*ROWS*COLS-1:0]     board_pc_o,
  output logic [CNT_W-1:0]           ships_placed_player_o,
  output logic [CNT_W-1:0]           ships_placed_pc_o,
  output logic [CNT_W-1:0]           cells_alive_player_o,
  output logic [CNT_W-1:0]           cells_alive_pc_o,
  output logic                       all_sunk_player_o,
  output logic                       all_sunk_pc_o
);

  // state | meaning
  // IDLE  | ready; validates PLACE, resolves ATTACK, dispatches CLEAR
  // CHECK | PLACE: scan one ship cell per cycle for overlap
  // WRITE | PLACE: write BARCO one cell per cycle
  // CLEAR | write AGUA to one cell per cycle over the whole board
  // RESP  | one-cycle response pulse
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CHECK = 3'd1;
  localparam logic [2:0] S_WRITE = 3'd2;
  localparam logic [2:0] S_CLEAR = 3'd3;
  localparam logic [2:0] S_RESP  = 3'd4;

  localparam logic [1:0] OP_PLACE  = 2'b00;
  localparam logic [1:0] OP_ATTACK = 2'b01;
  localparam logic [1:0] OP_CLEAR  = 2'b10;

  localparam logic [2:0] RC_OK      = 3'b000;
  localparam logic [2:0] RC_BOUNDS  = 3'b001;
  localparam logic [2:0] RC_OVERLAP = 3'b010;
  localparam logic [2:0] RC_LIMIT   = 3'b011;
  localparam logic [2:0] RC_HIT     = 3'b100;
  localparam logic [2:0] RC_MISS    = 3'b101;
  localparam logic [2:0] RC_REPEAT  = 3'b110;
  localparam logic [2:0] RC_OP      = 3'b111;

  localparam logic [1:0] AGUA        = 2'b00;
  localparam logic [1:0] BARCO       = 2'b01;
  localparam logic [1:0] ATACA_BARCO = 2'b10;
  localparam logic [1:0] ATACA_AGUA  = 2'b11;

  localparam int NCELL = ROWS * COLS;
  localparam int IDX_W = (NCELL > 1) ? $clog2(NCELL) : 1;
  localparam int EW    = ((COORD_W > LEN_W) ? COORD_W : LEN_W) + 1;

  logic [2:0]         state_q, state_d;
  logic [IDX_W-1:0]   step_q, step_d;
  logic               board_q, board_d;
  logic [COORD_W-1:0] row_q, row_d, col_q, col_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic               vert_q, vert_d;
  logic [2:0]         code_q, code_d;
  logic [CNT_W-1:0]   ships_q [2];
  logic [CNT_W-1:0]   ships_d [2];
  logic [CNT_W-1:0]   alive_q [2];
  logic [CNT_W-1:0]   alive_d [2];
  logic [1:0]         cell_q  [2][NCELL];

  logic               wr_en;
  logic               wr_board;
  logic [IDX_W-1:0]   wr_idx;
  logic [1:0]         wr_val;

  logic [EW-1:0]      end_r, end_c;
  logic               place_bad;
  logic               atk_in_range;
  logic [IDX_W-1:0]   atk_idx;
  logic [IDX_W-1:0]   cur_r, cur_c, cur_idx;
  logic [IDX_W-1:0]   last_step;

  // End cell of the proposed ship; a zero length is rejected before this matters.
  assign end_r = EW'(cmd_row_i) + (cmd_vert_i ? (EW'(cmd_len_i) - EW'(1)) : EW'(0));
  assign end_c = EW'(cmd_col_i) + (cmd_vert_i ? EW'(0) : (EW'(cmd_len_i) - EW'(1)));
  assign place_bad = (cmd_len_i == '0) || (cmd_len_i > LEN_W'(MAX_LEN)) ||
                     (end_r >= EW'(ROWS)) || (end_c >= EW'(COLS));

  assign atk_in_range = ({1'b0, cmd_row_i} < (COORD_W+1)'(ROWS)) &&
                        ({1'b0, cmd_col_i} < (COORD_W+1)'(COLS));
  assign atk_idx = IDX_W'(cmd_row_i) * IDX_W'(COLS) + IDX_W'(cmd_col_i);

  assign cur_r     = IDX_W'(row_q) + (vert_q ? step_q : '0);
  assign cur_c     = IDX_W'(col_q) + (vert_q ? '0 : step_q);
  assign cur_idx   = cur_r * IDX_W'(COLS) + cur_c;
  assign last_step = IDX_W'(len_q) - IDX_W'(1);

  always_comb begin
    state_d  = state_q;
    step_d   = step_q;
    board_d  = board_q;
    row_d    = row_q;
    col_d    = col_q;
    len_d    = len_q;
    vert_d   = vert_q;
    code_d   = code_q;
    ships_d  = ships_q;
    alive_d  = alive_q;
    wr_en    = 1'b0;
    wr_board = board_q;
    wr_idx   = cur_idx;
    wr_val   = BARCO;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid_i) begin
          board_d = cmd_board_i;
          row_d   = cmd_row_i;
          col_d   = cmd_col_i;
          len_d   = cmd_len_i;
          vert_d  = cmd_vert_i;
          step_d  = '0;
          state_d = S_RESP;
          case (cmd_op_i)
            OP_PLACE: begin
              if (place_bad)
                code_d = RC_BOUNDS;
              else if (ships_q[cmd_board_i] == CNT_W'(MAX_SHIPS))
                code_d = RC_LIMIT;
              else
                state_d = S_CHECK;
            end
            OP_ATTACK: begin
              if (!atk_in_range) begin
                code_d = RC_BOUNDS;
              end else begin
                wr_board = cmd_board_i;
                wr_idx   = atk_idx;
                case (cell_q[cmd_board_i][atk_idx])
                  BARCO: begin
                    wr_en  = 1'b1;
                    wr_val = ATACA_BARCO;
                    alive_d[cmd_board_i] = alive_q[cmd_board_i] - CNT_W'(1);
                    code_d = RC_HIT;
                  end
                  AGUA: begin
                    wr_en  = 1'b1;
                    wr_val = ATACA_AGUA;
                    code_d = RC_MISS;
                  end
                  default: code_d = RC_REPEAT;
                endcase
              end
            end
            OP_CLEAR: state_d = S_CLEAR;
            default:  code_d  = RC_OP;
          endcase
        end
      end
      S_CHECK: begin
        if (cell_q[board_q][cur_idx] != AGUA) begin
          code_d  = RC_OVERLAP;
          state_d = S_RESP;
        end else if (step_q == last_step) begin
          step_d  = '0;
          state_d = S_WRITE;
        end else begin
          step_d = step_q + IDX_W'(1);
        end
      end
      S_WRITE: begin
        wr_en = 1'b1;
        if (step_q == last_step) begin
          ships_d[board_q] = ships_q[board_q] + CNT_W'(1);
          alive_d[board_q] = alive_q[board_q] + CNT_W'(len_q);
          code_d  = RC_OK;
          state_d = S_RESP;
        end else begin
          step_d = step_q + IDX_W'(1);
        end
      end
      S_CLEAR: begin
        wr_en  = 1'b1;
        wr_idx = step_q;
        wr_val = AGUA;
        if (step_q == IDX_W'(NCELL - 1)) begin
          ships_d[board_q] = '0;
          alive_d[board_q] = '0;
          code_d  = RC_OK;
          state_d = S_RESP;
        end else begin
          step_d = step_q + IDX_W'(1);
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      step_q  <= '0;
      board_q <= 1'b0;
      row_q   <= '0;
      col_q   <= '0;
      len_q   <= '0;
      vert_q  <= 1'b0;
      code_q  <= RC_OK;
      for (int b = 0; b < 2; b++) begin
        ships_q[b] <= '0;
        alive_q[b] <= '0;
        for (int i = 0; i < NCELL; i++) cell_q[b][i] <= AGUA;
      end
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      board_q <= board_d;
      row_q   <= row_d;
      col_q   <= col_d;
      len_q   <= len_d;
      vert_q  <= vert_d;
      code_q  <= code_d;
      ships_q <= ships_d;
      alive_q <= alive_d;
      if (wr_en) cell_q[wr_board][wr_idx] <= wr_val;
    end
  end

  for (genvar i = 0; i < NCELL; i++) begin : g_flat
    assign board_player_o[2*i +: 2] = cell_q[0][i];
    assign board_pc_o[2*i +: 2]     = cell_q[1][i];
  end

  assign cmd_ready_o           = (state_q == S_IDLE);
  assign rsp_valid_o           = (state_q == S_RESP);
  assign rsp_code_o            = code_q;
  assign ships_placed_player_o = ships_q[0];
  assign ships_placed_pc_o     = ships_q[1];
  assign cells_alive_player_o  = alive_q[0];
  assign cells_alive_pc_o      = alive_q[1];
  assign all_sunk_player_o     = (ships_q[0] != '0) && (alive_q[0] == '0);
  assign all_sunk_pc_o         = (ships_q[1] != '0) && (alive_q[1] == '0);

endmodule

// File: tb/tb_battleship_board_engine.sv
// Directed bench for battleship_board_engine with hand-computed expectations.
module tb_battleship_board_engine;
  localparam int COORD_W = 3;
  localparam int LEN_W   = 2;
  localparam int CNT_W   = 5;
  localparam int NB      = 50;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               cmd_valid;
  logic               cmd_ready;
  logic [1:0]         cmd_op;
  logic               cmd_board;
  logic [COORD_W-1:0] cmd_row, cmd_col;
  logic [LEN_W-1:0]   cmd_len;
  logic               cmd_vert;
  logic               rsp_valid;
  logic [2:0]         rsp_code;
  logic [NB-1:0]      board_player, board_pc;
  logic [CNT_W-1:0]   ships_p, ships_pc, alive_p, alive_pc;
  logic               sunk_p, sunk_pc;

  int n_chk = 0;
  int n_fail = 0;
  int lat;
  logic [2:0] code;
  logic [NB-1:0] exp_p, exp_pc;
  logic seen;

  always #5 clk = ~clk;

  battleship_board_engine dut (
    .clk_i(clk), .rst_ni(rst_n),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
    .cmd_op_i(cmd_op), .cmd_board_i(cmd_board),
    .cmd_row_i(cmd_row), .cmd_col_i(cmd_col),
    .cmd_len_i(cmd_len), .cmd_vert_i(cmd_vert),
    .rsp_valid_o(rsp_valid), .rsp_code_o(rsp_code),
    .board_player_o(board_player), .board_pc_o(board_pc),
    .ships_placed_player_o(ships_p), .ships_placed_pc_o(ships_pc),
    .cells_alive_player_o(alive_p), .cells_alive_pc_o(alive_pc),
    .all_sunk_player_o(sunk_p), .all_sunk_pc_o(sunk_pc)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [1:0] op, input logic b, input int r, input int c,
                       input int l, input logic v);
    cmd_op    = op;
    cmd_board = b;
    cmd_row   = COORD_W'(r);
    cmd_col   = COORD_W'(c);
    cmd_len   = LEN_W'(l);
    cmd_vert  = v;
  endtask

  // Issue one command and return the cycle (accept edge = 0) of its response.
  task automatic do_cmd(input logic [1:0] op, input logic b, input int r, input int c,
                        input int l, input logic v, output int rlat, output logic [2:0] rcode);
    @(negedge clk);
    drive(op, b, r, c, l, v);
    cmd_valid = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    rlat  = -1;
    rcode = '0;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (rsp_valid) begin
        rlat  = k;
        rcode = rsp_code;
        break;
      end
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    drive(2'b00, 1'b0, 0, 0, 0, 1'b0);
    exp_p  = '0;
    exp_pc = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    chk("rst_ready", cmd_ready, 1);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_code", rsp_code, 0);
    chk("rst_board_p", board_player, 0);
    chk("rst_board_pc", board_pc, 0);
    chk("rst_counts", {ships_p, alive_p, ships_pc, alive_pc}, 0);
    chk("rst_sunk", {sunk_p, sunk_pc}, 0);

    // Player ship (1,1) len 3 horizontal
    do_cmd(2'b00, 1'b0, 1, 1, 3, 1'b0, lat, code);
    exp_p[2*6 +: 2] = 2'b01; exp_p[2*7 +: 2] = 2'b01; exp_p[2*8 +: 2] = 2'b01;
    chk("place1_lat", lat, 7);
    chk("place1_code", code, 3'b000);
    chk("place1_board", board_player, exp_p);
    chk("place1_ships", ships_p, 1);
    chk("place1_alive", alive_p, 3);
    chk("place1_sunk", sunk_p, 0);

    // Vertical (0,2) len 3 crosses (1,2)
    do_cmd(2'b00, 1'b0, 0, 2, 3, 1'b1, lat, code);
    chk("overlap_lat", lat, 3);
    chk("overlap_code", code, 3'b010);
    chk("overlap_board", board_player, exp_p);
    chk("overlap_counts", {ships_p, alive_p}, {5'd1, 5'd3});

    do_cmd(2'b00, 1'b1, 4, 3, 3, 1'b0, lat, code);
    chk("bounds_h_lat", lat, 1);
    chk("bounds_h_code", code, 3'b001);
    do_cmd(2'b00, 1'b1, 0, 0, 0, 1'b0, lat, code);
    chk("bounds_len0_code", code, 3'b001);
    do_cmd(2'b00, 1'b1, 3, 0, 3, 1'b1, lat, code);
    chk("bounds_v_code", code, 3'b001);
    chk("bounds_pc_board", board_pc, 0);
    chk("bounds_pc_ships", ships_pc, 0);

    for (int c = 0; c < 5; c++) begin
      do_cmd(2'b00, 1'b1, 0, c, 1, 1'b0, lat, code);
      exp_pc[2*c +: 2] = 2'b01;
      chk("fleet_lat", lat, 3);
      chk("fleet_code", code, 3'b000);
    end
    chk("fleet_ships", ships_pc, 5);
    chk("fleet_alive", alive_pc, 5);
    do_cmd(2'b00, 1'b1, 4, 4, 1, 1'b0, lat, code);
    chk("limit_lat", lat, 1);
    chk("limit_code", code, 3'b011);
    chk("limit_board", board_pc, exp_pc);
    chk("limit_ships", ships_pc, 5);

    do_cmd(2'b10, 1'b1, 0, 0, 0, 1'b0, lat, code);
    exp_pc = '0;
    chk("clr_pc_lat", lat, 26);
    chk("clr_pc_code", code, 3'b000);
    chk("clr_pc_board", board_pc, 0);
    chk("clr_pc_counts", {ships_pc, alive_pc}, 0);
    chk("clr_pc_player_kept", board_player, exp_p);
    chk("clr_pc_player_ships", ships_p, 1);

    do_cmd(2'b00, 1'b1, 2, 0, 2, 1'b0, lat, code);
    exp_pc[2*10 +: 2] = 2'b01; exp_pc[2*11 +: 2] = 2'b01;
    chk("place2_lat", lat, 5);
    chk("place2_board", board_pc, exp_pc);
    chk("place2_alive", alive_pc, 2);

    do_cmd(2'b01, 1'b1, 2, 0, 0, 1'b0, lat, code);
    exp_pc[2*10 +: 2] = 2'b10;
    chk("hit1_lat", lat, 1);
    chk("hit1_code", code, 3'b100);
    chk("hit1_alive", alive_pc, 1);
    chk("hit1_sunk", sunk_pc, 0);
    do_cmd(2'b01, 1'b1, 2, 1, 0, 1'b0, lat, code);
    exp_pc[2*11 +: 2] = 2'b10;
    chk("hit2_code", code, 3'b100);
    chk("hit2_alive", alive_pc, 0);
    chk("hit2_sunk", sunk_pc, 1);
    chk("hit2_board", board_pc, exp_pc);
    do_cmd(2'b01, 1'b1, 2, 1, 0, 1'b0, lat, code);
    chk("repeat_code", code, 3'b110);
    chk("repeat_board", board_pc, exp_pc);
    do_cmd(2'b01, 1'b1, 4, 4, 0, 1'b0, lat, code);
    exp_pc[2*24 +: 2] = 2'b11;
    chk("miss_code", code, 3'b101);
    chk("miss_board", board_pc, exp_pc);
    do_cmd(2'b01, 1'b1, 0, 5, 0, 1'b0, lat, code);
    chk("atk_bounds_lat", lat, 1);
    chk("atk_bounds_code", code, 3'b001);
    chk("atk_bounds_board", board_pc, exp_pc);

    do_cmd(2'b01, 1'b0, 1, 2, 0, 1'b0, lat, code);
    exp_p[2*7 +: 2] = 2'b10;
    chk("hit_p_code", code, 3'b100);
    chk("hit_p_alive", alive_p, 2);
    chk("hit_p_board", board_player, exp_p);
    do_cmd(2'b10, 1'b0, 0, 0, 0, 1'b0, lat, code);
    exp_p = '0;
    chk("clr_p_lat", lat, 26);
    chk("clr_p_code", code, 3'b000);
    chk("clr_p_board", board_player, 0);
    chk("clr_p_counts", {ships_p, alive_p}, 0);
    chk("clr_p_sunk", sunk_p, 0);
    chk("clr_p_pc_kept", board_pc, exp_pc);
    chk("clr_p_pc_sunk", sunk_pc, 1);

    do_cmd(2'b11, 1'b0, 0, 0, 0, 1'b0, lat, code);
    chk("rejop_lat", lat, 1);
    chk("rejop_code", code, 3'b111);

    // A command held valid while busy must be dropped.
    @(negedge clk);
    drive(2'b00, 1'b0, 0, 0, 3, 1'b0);
    cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    lat = -1;
    code = '0;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (k == 1) drive(2'b01, 1'b1, 3, 3, 0, 1'b0);
      if (k == 4) cmd_valid = 1'b0;
      if (rsp_valid && lat < 0) begin
        lat  = k;
        code = rsp_code;
      end
      if (lat > 0) break;
    end
    exp_p[2*0 +: 2] = 2'b01; exp_p[2*1 +: 2] = 2'b01; exp_p[2*2 +: 2] = 2'b01;
    chk("busy_lat", lat, 7);
    chk("busy_code", code, 3'b000);
    chk("busy_pc_kept", board_pc, exp_pc);
    chk("busy_player", board_player, exp_p);
    repeat (3) @(negedge clk);
    chk("busy_no_extra_rsp", rsp_valid, 0);

    // Reset in the middle of the WRITE phase.
    @(negedge clk);
    drive(2'b00, 1'b0, 3, 0, 3, 1'b0);
    cmd_valid = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    repeat (5) @(negedge clk);
    chk("midw_busy", cmd_ready, 0);
    chk("midw_partial", board_player[2*15 +: 2], 2'b01);
    rst_n = 1'b0;
    #1;
    chk("midrst_board_p", board_player, 0);
    chk("midrst_board_pc", board_pc, 0);
    chk("midrst_counts", {ships_p, alive_p, ships_pc, alive_pc}, 0);
    chk("midrst_rsp_valid", rsp_valid, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (rsp_valid) seen = 1'b1;
    end
    chk("midrst_no_rsp", seen, 0);
    chk("midrst_ready", cmd_ready, 1);
    chk("midrst_code", rsp_code, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
